// File: rtl/ysyx_24070016_rf_wb_arbiter.sv
// Write-back arbiter and register scoreboard for the RV32E register file.
// Shares the single register-file write port between the EXU (req0) and the
// LSU (req1) with round-robin priority, and tracks pending destination
// registers so the IDU can stall on read-after-write hazards.
module ysyx_24070016_rf_wb_arbiter #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int NREG       = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0_valid,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_data,
    output logic                  req0_ready,
    input  logic                  req1_valid,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_data,
    output logic                  req1_ready,
    input  logic                  iss_valid,
    input  logic [ADDR_WIDTH-1:0] iss_rd,
    input  logic [ADDR_WIDTH-1:0] rs1,
    input  logic [ADDR_WIDTH-1:0] rs2,
    output logic                  rs1_busy,
    output logic                  rs2_busy,
    output logic                  rf_wen,
    output logic [ADDR_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata,
    output logic                  err
);

    // One extra bit so NREG == 2**ADDR_WIDTH still compares correctly.
    localparam logic [ADDR_WIDTH:0] NREG_LIMIT = (ADDR_WIDTH+1)'(NREG);

    logic [NREG-1:0]       pending;
    logic [NREG-1:0]       pending_nxt;
    logic                  last_grant;
    logic                  grant0;
    logic                  grant1;
    logic                  accept;
    logic [ADDR_WIDTH-1:0] acc_addr;
    logic [DATA_WIDTH-1:0] acc_data;
    logic                  acc_legal;
    logic                  wb_hit;
    logic                  err_nxt;

    // Round-robin grant; on contention the requester that did not win last goes.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!rst) begin
            if (req0_valid && req1_valid) begin
                if (last_grant) grant0 = 1'b1;
                else            grant1 = 1'b1;
            end else if (req0_valid) begin
                grant0 = 1'b1;
            end else if (req1_valid) begin
                grant1 = 1'b1;
            end
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign accept     = grant0 | grant1;
    assign acc_addr   = grant1 ? req1_addr : req0_addr;
    assign acc_data   = grant1 ? req1_data : req0_data;
    // x0 and unimplemented registers complete the handshake but never write.
    assign acc_legal  = (acc_addr != '0) && ({1'b0, acc_addr} < NREG_LIMIT);

    // Scoreboard update: issue sets, retirement clears, issue wins on a tie.
    // Also flags a retirement to a register that was never pending.
    always_comb begin
        pending_nxt    = pending;
        pending_nxt[0] = 1'b0;
        wb_hit         = 1'b0;
        for (int i = 1; i < NREG; i++) begin
            logic set_i;
            logic clr_i;
            set_i = iss_valid && (iss_rd == ADDR_WIDTH'(i));
            clr_i = rf_wen && (rf_waddr == ADDR_WIDTH'(i));
            pending_nxt[i] = set_i | (pending[i] & ~clr_i);
            if (clr_i) wb_hit = pending[i] | set_i;
        end
        err_nxt = err | (rf_wen & ~wb_hit);
    end

    // Hazard queries read registered state only.
    always_comb begin
        rs1_busy = 1'b0;
        rs2_busy = 1'b0;
        for (int i = 1; i < NREG; i++) begin
            if (rs1 == ADDR_WIDTH'(i)) rs1_busy = pending[i];
            if (rs2 == ADDR_WIDTH'(i)) rs2_busy = pending[i];
        end
    end

    // Scoreboard, sticky error and grant history.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending    <= '0;
            err        <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            pending <= pending_nxt;
            err     <= err_nxt;
            if (accept) last_grant <= grant1;
        end
    end

    // Registered write port; address/data hold when nothing is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_wen   <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else if (accept) begin
            rf_wen   <= acc_legal;
            rf_waddr <= acc_addr;
            rf_wdata <= acc_data;
        end else begin
            rf_wen   <= 1'b0;
        end
    end

endmodule
